// File: rtl/instruction_prefetch_queue.sv
// Tagged prefetch queue between a variable-latency instruction memory and the fetch stage.
// The head is released only when its tag matches current_pc; any mismatch flushes and restarts there.
module instruction_prefetch_queue #(
  parameter int              size     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [size-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] current_pc,
  input  logic            buble,
  output logic [size-1:0] instruction_o,
  output logic            instruction_valid_o,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [size-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [size-1:0] imem_resp_data
);
  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [size-1:0]  req_pc;
  logic [size-1:0]  ent_addr [DEPTH];
  logic [size-1:0]  ent_data [DEPTH];
  logic [DEPTH-1:0] ent_filled;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    fill_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    unfilled;
  logic [CW-1:0]    drop_cnt;

  logic        head_hit;
  logic        mismatch;
  logic        accept;
  logic        resp_drop;
  logic        resp_fill;
  logic        pop;
  logic [CW:0] occupancy;

  assign head_hit  = (count != '0) && (ent_addr[head] == current_pc);
  assign mismatch  = ((count != '0) && !head_hit) ||
                     ((count == '0) && (drop_cnt == '0) && (req_pc != current_pc));
  // Dropped responses still occupy memory-side slots, so they count against capacity.
  assign occupancy = {1'b0, count} + {1'b0, drop_cnt};

  assign imem_req_valid = !mismatch && ({1'b0, count} < DEPTH_W) && (occupancy < DEPTH_W);
  assign imem_req_addr  = req_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_cnt != '0);
  assign resp_fill = imem_resp_valid && (drop_cnt == '0) && (unfilled != '0);

  assign instruction_valid_o = head_hit && ent_filled[head];
  assign instruction_o       = instruction_valid_o ? ent_data[head] : '0;
  assign pop                 = instruction_valid_o && !buble;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_pc     <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      fill_ptr   <= '0;
      count      <= '0;
      unfilled   <= '0;
      drop_cnt   <= '0;
      ent_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else if (mismatch) begin
      req_pc     <= current_pc;
      head       <= '0;
      tail       <= '0;
      fill_ptr   <= '0;
      count      <= '0;
      unfilled   <= '0;
      ent_filled <= '0;
      // A response landing this cycle settles its own entry before the flush, so it is not owed.
      drop_cnt   <= drop_cnt - CW'(resp_drop) + unfilled - CW'(resp_fill);
    end else begin
      if (pop) begin
        ent_filled[head] <= 1'b0;
        head             <= head + PW'(1);
      end
      if (accept) begin
        ent_addr[tail]   <= req_pc;
        ent_filled[tail] <= 1'b0;
        tail             <= tail + PW'(1);
        req_pc           <= req_pc + size'(4);
      end
      if (resp_fill) begin
        ent_data[fill_ptr]   <= imem_resp_data;
        ent_filled[fill_ptr] <= 1'b1;
        fill_ptr             <= fill_ptr + PW'(1);
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      count    <= count + CW'(accept) - CW'(pop);
      unfilled <= unfilled + CW'(accept) - CW'(resp_fill);
    end
  end

  resp_owned: assert property (@(posedge clk) disable iff (!reset)
    imem_resp_valid |-> ((drop_cnt != '0) || (unfilled != '0)));

endmodule
